// File: rtl/nes_vram_pkg.sv
// Shared VRAM definitions: mirroring codes, debug FSM states, read-owner tags.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nes_vram_pkg;

    // Nametable mirroring modes as presented by the cartridge
    localparam logic [1:0] MIRROR_HORZ  = 2'd0;
    localparam logic [1:0] MIRROR_VERT  = 2'd1;
    localparam logic [1:0] MIRROR_ONE_A = 2'd2;
    localparam logic [1:0] MIRROR_ONE_B = 2'd3;

    // Debug port sequencer states
    localparam logic [1:0] DBG_IDLE = 2'd0;
    localparam logic [1:0] DBG_WAIT = 2'd1;
    localparam logic [1:0] DBG_ACK  = 2'd2;

    // Who issued the read whose data returns in the following cycle
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_PPU  = 2'd1;
    localparam logic [1:0] OWN_DBG  = 2'd2;

    // One VRAM command as seen on the single RAM port
    typedef struct packed {
        logic        en;
        logic        r_nw;
        logic [10:0] a;
        logic [7:0]  d;
    } vram_cmd_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundles PPU, debug and VRAM-side signals of the nametable arbiter.
// Latency: n/a (wiring only).
// Backpressure: debug side uses level request held until ack; PPU is never stalled.
interface vram_arbiter_if;
    logic [1:0]  mirror_cfg_in;
    logic        ppu_req_in;
    logic        ppu_r_nw_in;
    logic [13:0] ppu_a_in;
    logic [7:0]  ppu_d_in;
    logic [7:0]  ppu_d_out;
    logic        ppu_rd_valid_out;
    logic        dbg_req_in;
    logic        dbg_r_nw_in;
    logic [10:0] dbg_a_in;
    logic [7:0]  dbg_d_in;
    logic [7:0]  dbg_d_out;
    logic        dbg_ack_out;
    logic        dbg_starve_out;
    logic        vram_en_out;
    logic        vram_r_nw_out;
    logic [10:0] vram_a_out;
    logic [7:0]  vram_d_out;
    logic [7:0]  vram_d_in;

    // Arbiter side
    modport master (
        input  mirror_cfg_in,
        input  ppu_req_in, ppu_r_nw_in, ppu_a_in, ppu_d_in,
        output ppu_d_out, ppu_rd_valid_out,
        input  dbg_req_in, dbg_r_nw_in, dbg_a_in, dbg_d_in,
        output dbg_d_out, dbg_ack_out, dbg_starve_out,
        output vram_en_out, vram_r_nw_out, vram_a_out, vram_d_out,
        input  vram_d_in
    );

    // Requesters and RAM side
    modport slave (
        output mirror_cfg_in,
        output ppu_req_in, ppu_r_nw_in, ppu_a_in, ppu_d_in,
        input  ppu_d_out, ppu_rd_valid_out,
        output dbg_req_in, dbg_r_nw_in, dbg_a_in, dbg_d_in,
        input  dbg_d_out, dbg_ack_out, dbg_starve_out,
        input  vram_en_out, vram_r_nw_out, vram_a_out, vram_d_out,
        output vram_d_in
    );
endinterface

// File: rtl/vram_mirror.sv
// Maps a 14-bit PPU nametable address onto the 2KB physical VRAM.
// Latency: combinational.
// Backpressure: none.
module vram_mirror
    import nes_vram_pkg::*;
(
    input  logic [13:0] i_a,
    input  logic [1:0]  i_cfg,
    output logic [10:0] o_a
);

    // Bits above the nametable window never influence the physical address
    logic [1:0] w_unused_hi;
    assign w_unused_hi = i_a[13:12];

    // Pick which address bit (or constant) selects the physical 1KB page
    always_comb begin
        o_a = {1'b0, i_a[9:0]};
        case (i_cfg)
            MIRROR_HORZ:  o_a = {i_a[11], i_a[9:0]};
            MIRROR_VERT:  o_a = {i_a[10], i_a[9:0]};
            MIRROR_ONE_A: o_a = {1'b0,    i_a[9:0]};
            MIRROR_ONE_B: o_a = {1'b1,    i_a[9:0]};
            default:      o_a = {1'b0,    i_a[9:0]};
        endcase
    end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates the single-port nametable VRAM between PPU (absolute priority) and debug port.
// Latency: grant cycle drives RAM combinationally; PPU read data / debug ack one cycle later.
// Backpressure: PPU never stalls; debug request waits in WAIT while PPU holds the port.
module vram_arbiter
    import nes_vram_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    vram_arbiter_if.master bus
);

    localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [7:0]  r_starve_cnt;
    logic [1:0]  r_owner;
    logic [7:0]  r_dbg_d;

    logic        w_ppu_grant;
    logic        w_dbg_pending;
    logic        w_dbg_grant;
    logic        w_dbg_blocked;
    logic [10:0] w_ppu_pa;
    vram_cmd_t   w_cmd;

    vram_mirror u_mirror (
        .i_a   (bus.ppu_a_in),
        .i_cfg (bus.mirror_cfg_in),
        .o_a   (w_ppu_pa)
    );

    // Nothing is granted while reset is held, so no access can sneak out
    assign w_ppu_grant   = !rst_in && bus.ppu_req_in;
    assign w_dbg_pending = bus.dbg_req_in && (r_state == DBG_IDLE || r_state == DBG_WAIT);
    assign w_dbg_grant   = !rst_in && w_dbg_pending && !bus.ppu_req_in;
    assign w_dbg_blocked = w_dbg_pending && bus.ppu_req_in;

    // Build the RAM command from whichever requester owns this cycle
    always_comb begin
        w_cmd = '{en: 1'b0, r_nw: 1'b1, a: 11'd0, d: 8'd0};
        if (w_ppu_grant) begin
            w_cmd.en   = 1'b1;
            w_cmd.r_nw = bus.ppu_r_nw_in;
            w_cmd.a    = w_ppu_pa;
            w_cmd.d    = bus.ppu_r_nw_in ? 8'd0 : bus.ppu_d_in;
        end else if (w_dbg_grant) begin
            w_cmd.en   = 1'b1;
            w_cmd.r_nw = bus.dbg_r_nw_in;
            w_cmd.a    = bus.dbg_a_in;
            w_cmd.d    = bus.dbg_r_nw_in ? 8'd0 : bus.dbg_d_in;
        end
    end

    assign bus.vram_en_out   = w_cmd.en;
    assign bus.vram_r_nw_out = w_cmd.r_nw;
    assign bus.vram_a_out    = w_cmd.a;
    assign bus.vram_d_out    = w_cmd.d;

    // Debug sequencer: IDLE -> (WAIT while PPU busy) -> ACK -> IDLE
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= DBG_IDLE;
        end else begin
            case (r_state)
                DBG_IDLE: begin
                    if (bus.dbg_req_in)
                        r_state <= bus.ppu_req_in ? DBG_WAIT : DBG_ACK;
                end
                DBG_WAIT: begin
                    if (!bus.dbg_req_in)
                        r_state <= DBG_IDLE;
                    else if (!bus.ppu_req_in)
                        r_state <= DBG_ACK;
                end
                DBG_ACK:  r_state <= DBG_IDLE;
                default:  r_state <= DBG_IDLE;
            endcase
        end
    end

    // Count consecutive blocked cycles of a pending debug request, saturating
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_starve_cnt <= 8'd0;
        end else if (w_dbg_grant || (r_state == DBG_IDLE && !bus.dbg_req_in)) begin
            r_starve_cnt <= 8'd0;
        end else if (w_dbg_blocked && r_starve_cnt != LP_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Remember who issued this cycle's read so the returning data is steered correctly
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_owner <= OWN_NONE;
        else if (w_ppu_grant && bus.ppu_r_nw_in)
            r_owner <= OWN_PPU;
        else if (w_dbg_grant && bus.dbg_r_nw_in)
            r_owner <= OWN_DBG;
        else
            r_owner <= OWN_NONE;
    end

    // Capture debug read data so it stays visible until the next debug read
    always_ff @(posedge clk_in) begin
        if (rst_in)
            r_dbg_d <= 8'd0;
        else if (r_owner == OWN_DBG)
            r_dbg_d <= bus.vram_d_in;
    end

    // Outputs are forced to reset values while reset is held, discarding any read in flight
    assign bus.ppu_rd_valid_out = !rst_in && (r_owner == OWN_PPU);
    assign bus.ppu_d_out        = bus.ppu_rd_valid_out ? bus.vram_d_in : 8'd0;
    assign bus.dbg_ack_out      = !rst_in && (r_state == DBG_ACK);
    assign bus.dbg_d_out        = rst_in ? 8'd0 :
                                  (r_owner == OWN_DBG) ? bus.vram_d_in : r_dbg_d;
    assign bus.dbg_starve_out   = !rst_in && (r_starve_cnt == LP_LIMIT);

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 2KB synchronous VRAM.
// Latency: checks read-valid and ack cycles against grant cycle + 1.
// Backpressure: exercises PPU-over-debug contention and starvation flag.
module tb_vram_arbiter;
    import nes_vram_pkg::*;

    localparam int LIM = 3;

    logic core_clk = 1'b0;
    logic rst_in   = 1'b1;
    always #5 core_clk = ~core_clk;

    vram_arbiter_if bus ();

    vram_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk_in (core_clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // Behavioural VRAM: write commits at end of enable cycle, read data next cycle
    logic [7:0] vram_mem [0:2047];
    logic [7:0] vram_rdq = 8'd0;
    always @(posedge core_clk) begin
        if (bus.vram_en_out) begin
            if (!bus.vram_r_nw_out) vram_mem[bus.vram_a_out] <= bus.vram_d_out;
            else                    vram_rdq <= vram_mem[bus.vram_a_out];
        end
    end
    assign bus.vram_d_in = vram_rdq;

    // Reference model state
    logic [7:0] ref_mem [0:2047];
    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] d; } ppu_exp_t;
    typedef struct { int cyc; logic rd; logic [7:0] d; } dbg_exp_t;
    ppu_exp_t ppu_q [$];
    dbg_exp_t dbg_q [$];
    ppu_exp_t pe;
    dbg_exp_t de;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [10:0] ref_map(input logic [13:0] a, input logic [1:0] cfg);
        logic [10:0] low;
        low = {1'b0, a[9:0]};
        case (cfg)
            2'd0:    return a[11] ? (low | 11'h400) : low;
            2'd1:    return a[10] ? (low | 11'h400) : low;
            2'd2:    return low;
            default: return low | 11'h400;
        endcase
    endfunction

    // Output monitor: every pulse must match the head of its scoreboard queue
    always @(negedge core_clk) begin
        if (bus.ppu_rd_valid_out) begin
            if (ppu_q.size() == 0) chk("ppu_spurious_valid", 1, 0);
            else begin
                pe = ppu_q.pop_front();
                chk("ppu_valid_cycle", cyc, pe.cyc);
                chk("ppu_rd_data", {24'd0, bus.ppu_d_out}, {24'd0, pe.d});
            end
        end
        if (bus.dbg_ack_out) begin
            if (dbg_q.size() == 0) chk("dbg_spurious_ack", 1, 0);
            else begin
                de = dbg_q.pop_front();
                chk("dbg_ack_cycle", cyc, de.cyc);
                if (de.rd) chk("dbg_rd_data", {24'd0, bus.dbg_d_out}, {24'd0, de.d});
            end
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic chk_idle_bus(input string tag);
        chk({tag, "_en"},   bus.vram_en_out, 0);
        chk({tag, "_rnw"},  bus.vram_r_nw_out, 1);
        chk({tag, "_addr"}, bus.vram_a_out, 0);
        chk({tag, "_wd"},   bus.vram_d_out, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_idle_bus(tag);
        chk({tag, "_pvld"},   bus.ppu_rd_valid_out, 0);
        chk({tag, "_pd"},     bus.ppu_d_out, 0);
        chk({tag, "_ack"},    bus.dbg_ack_out, 0);
        chk({tag, "_dd"},     bus.dbg_d_out, 0);
        chk({tag, "_starve"}, bus.dbg_starve_out, 0);
    endtask

    // Drive one PPU access in the current cycle and check the RAM command
    task automatic ppu_drive(input logic r_nw, input logic [13:0] a, input logic [7:0] d,
                             input logic expect_data);
        logic [10:0] m;
        bus.ppu_req_in  = 1'b1;
        bus.ppu_r_nw_in = r_nw;
        bus.ppu_a_in    = a;
        bus.ppu_d_in    = d;
        #1;
        m = ref_map(a, bus.mirror_cfg_in);
        chk("ppu_en",   bus.vram_en_out, 1);
        chk("ppu_addr", bus.vram_a_out, m);
        chk("ppu_rnw",  bus.vram_r_nw_out, r_nw);
        if (r_nw) begin
            if (expect_data) ppu_q.push_back('{cyc + 1, ref_mem[m]});
        end else begin
            chk("ppu_wdata", bus.vram_d_out, d);
            ref_mem[m] = d;
        end
    endtask

    task automatic ppu_op(input logic r_nw, input logic [13:0] a, input logic [7:0] d);
        ppu_drive(r_nw, a, d, 1'b1);
        tick();
        bus.ppu_req_in = 1'b0;
    endtask

    // Debug access with n PPU cycles blocking it first; total latency n + 2 cycles
    task automatic dbg_access(input int n, input logic r_nw, input logic [10:0] a,
                              input logic [7:0] d);
        int start;
        start           = cyc;
        bus.dbg_req_in  = 1'b1;
        bus.dbg_r_nw_in = r_nw;
        bus.dbg_a_in    = a;
        bus.dbg_d_in    = d;
        for (int k = 0; k < n; k++) begin
            ppu_drive(1'b1, 14'h2000 + 14'(k * 37), 8'd0, 1'b1);
            chk("starve_blocked", bus.dbg_starve_out, (k >= LIM));
            tick();
        end
        bus.ppu_req_in = 1'b0;
        #1;
        chk("dbg_en",   bus.vram_en_out, 1);
        chk("dbg_addr", bus.vram_a_out, a);
        chk("dbg_rnw",  bus.vram_r_nw_out, r_nw);
        chk("starve_at_grant", bus.dbg_starve_out, (n >= LIM));
        if (!r_nw) begin
            chk("dbg_wdata", bus.vram_d_out, d);
            ref_mem[a] = d;
        end
        dbg_q.push_back('{start + n + 1, r_nw, ref_mem[a]});
        tick();
        bus.dbg_req_in = 1'b0;
        chk("starve_after_grant", bus.dbg_starve_out, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            vram_mem[i] = 8'd0;
            ref_mem[i]  = 8'd0;
        end
        bus.mirror_cfg_in = MIRROR_VERT;
        bus.ppu_req_in    = 1'b0;
        bus.ppu_r_nw_in   = 1'b1;
        bus.ppu_a_in      = 14'd0;
        bus.ppu_d_in      = 8'd0;
        bus.dbg_req_in    = 1'b0;
        bus.dbg_r_nw_in   = 1'b1;
        bus.dbg_a_in      = 11'd0;
        bus.dbg_d_in      = 8'd0;

        // Reset state
        repeat (3) tick();
        chk_reset_outs("in_reset");
        rst_in = 1'b0;
        tick();
        chk_reset_outs("post_reset");

        // Vertical mirroring: $2400 and $2C00 alias to $400
        bus.mirror_cfg_in = MIRROR_VERT;
        ppu_op(1'b0, 14'h2400, 8'hAA);
        ppu_op(1'b1, 14'h2C00, 8'h00);
        tick();
        chk_idle_bus("idle_after_ppu");

        // Other modes, $2800 write of $55
        bus.mirror_cfg_in = MIRROR_HORZ;  ppu_op(1'b0, 14'h2800, 8'h55);
        bus.mirror_cfg_in = MIRROR_ONE_A; ppu_op(1'b0, 14'h2800, 8'h55);
        bus.mirror_cfg_in = MIRROR_ONE_B; ppu_op(1'b0, 14'h2800, 8'h55);
        tick();
        dbg_access(0, 1'b1, 11'h400, 8'h00);
        dbg_access(0, 1'b1, 11'h000, 8'h00);

        // Debug write then read of $7FF; data held across idle and PPU reads
        dbg_access(0, 1'b0, 11'h7FF, 8'h3C);
        dbg_access(0, 1'b1, 11'h7FF, 8'h00);
        for (int i = 0; i < 10; i++) begin
            chk("dbg_d_hold_idle", bus.dbg_d_out, 8'h3C);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            ppu_op(1'b1, 14'h2400 + 14'(i), 8'h00);
            chk("dbg_d_hold_ppu", bus.dbg_d_out, 8'h3C);
        end
        tick();

        // Random PPU traffic across all mirroring modes
        for (int i = 0; i < 16; i++) begin
            bus.mirror_cfg_in = 2'($urandom_range(0, 3));
            ppu_op(1'($urandom_range(0, 1)), 14'(14'h2000 + $urandom_range(0, 14'h1EFF)),
                   8'($urandom_range(0, 255)));
        end
        tick();

        // Contention beyond the starvation limit, then below it
        dbg_access(5, 1'b1, 11'h400, 8'h00);
        dbg_access(2, 1'b0, 11'h123, 8'h5A);
        dbg_access(0, 1'b1, 11'h123, 8'h00);

        // Reset in the cycle after a PPU read grant discards the read
        ppu_drive(1'b1, 14'h2000, 8'h00, 1'b0);
        tick();
        bus.ppu_req_in = 1'b0;
        rst_in = 1'b1;
        #1;
        chk_reset_outs("mid_reset");
        tick();
        rst_in = 1'b0;
        tick();
        chk_reset_outs("after_mid_reset");
        chk("fsm_idle", dut.r_state, DBG_IDLE);

        repeat (3) tick();
        chk("ppu_q_drained", ppu_q.size(), 0);
        chk("dbg_q_drained", dbg_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Sequencer and arbiter for the 2KB nametable VRAM. Shares the single-port synchronous VRAM between the PPU rendering/register path and the host debug port. Applies cartridge nametable mirroring to PPU addresses. Returns read data with fixed one-cycle RAM latency. Sits between the PPU, the debug controller and the vram block.

## Interface
Parameters:
- STARVE_LIMIT, 8: number of consecutive blocked cycles after which a pending debug request raises dbg_starve_out; legal range 1–255.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- mirror_cfg_in  in  2  nametable mirroring: 0 horizontal, 1 vertical, 2 single-screen A, 3 single-screen B
- ppu_req_in  in  1  PPU access request; single-cycle, always granted
- ppu_r_nw_in  in  1  1 = read, 0 = write
- ppu_a_in  in  14  PPU address; PPU asserts request only for $2000–$3EFF
- ppu_d_in  in  8  PPU write data
- ppu_d_out  out  8  PPU read data, valid only while ppu_rd_valid_out is high
- ppu_rd_valid_out  out  1  one-cycle pulse, read data valid
- dbg_req_in  in  1  debug request; level, held with stable address/data until ack
- dbg_r_nw_in  in  1  1 = read, 0 = write
- dbg_a_in  in  11  physical VRAM address, no mirroring applied
- dbg_d_in  in  8  debug write data
- dbg_d_out  out  8  last debug read data; held until the next debug read ack
- dbg_ack_out  out  1  one-cycle pulse, debug access complete
- dbg_starve_out  out  1  pending debug request blocked for ≥ STARVE_LIMIT cycles
- vram_en_out  out  1  VRAM chip enable
- vram_r_nw_out  out  1  VRAM read/write select: 1 = read, 0 = write
- vram_a_out  out  11  VRAM address
- vram_d_out  out  8  VRAM write data
- vram_d_in  in  8  VRAM read data; one cycle after the enable cycle

## Operation
- Grant cycle: in any cycle with ppu_req_in=1, the PPU is granted. Otherwise a debug request in the IDLE or WAIT state is granted.
- PPU has absolute priority. A simultaneous debug request goes to WAIT and the starvation counter increments.
- Mirroring uses mirror_cfg_in sampled in the grant cycle:
  - horizontal: {a[11], a[9:0]}
  - vertical: {a[10], a[9:0]}
  - single A: {0, a[9:0]}
  - single B: {1, a[9:0]}
- Debug FSM states:
  - IDLE: request and grant → ACK. Request and PPU busy → WAIT.
  - WAIT: grant → ACK.
  - ACK: dbg_ack_out=1; returns to IDLE. dbg_req_in is ignored in ACK.
- Read-owner flop records the requester (none/PPU/debug) of each read issued. Writes record none for PPU; a debug write still reaches ACK.
- Starvation counter saturates at STARVE_LIMIT and clears on debug grant or when dbg_req_in is low in IDLE. dbg_starve_out = (count == STARVE_LIMIT).
- Non-grant cycles: vram_en_out=0, vram_r_nw_out=1, vram_a_out=0, vram_d_out=0.
- Reset values: all outputs 0 except vram_r_nw_out=1. FSM → IDLE, counter → 0, read owner → none, dbg_d_out → 0.
- Reset mid-operation: a pending read is discarded, and no ppu_rd_valid_out or dbg_ack_out pulse follows reset.
- mirror_cfg_in changes between accesses take effect on the next grant; no flush is needed.

## Timing
- Cycle N (grant): vram_en_out=1 and the VRAM command is driven combinationally from the granted requester. The write commits at the end of N.
- Cycle N+1:
  - PPU read: ppu_rd_valid_out=1 and ppu_d_out=vram_d_in.
  - Debug access: dbg_ack_out=1. For a read, dbg_d_out=vram_d_in in N+1 and is registered and held from N+2.
- PPU throughput is one access per cycle. Back-to-back PPU reads produce back-to-back valid pulses.
- Debug latency is 2 cycles unblocked, or 2 + k cycles when blocked k cycles.
- A debug requester may present its next request from N+2.

## Structure
- Shared package/include `nes_vram_pkg` holds:
  - mirroring codes MIRROR_HORZ/VERT/ONE_A/ONE_B
  - debug FSM state encodings
  - read-owner encodings
- Sub-module `vram_mirror`: combinational 14-bit→11-bit mapper. It is reused by the cartridge/mapper logic.
- The arbiter instantiates `vram_mirror` and drives the vram block ports directly.

## Test plan
- Vertical mirroring: PPU writes $AA to $2400, then reads $2C00 → vram_a_out=$400 both times; ppu_d_out=$AA with valid exactly one cycle after the read grant.
- Horizontal and single-screen modes: PPU writes $55 to $2800. Horizontal → vram_a_out=$400. Single A → $000. Single B → $400. Debug read of the mapped address returns $55.
- Contention: dbg_req held while PPU requests 5 consecutive cycles → no debug enable during those cycles; debug granted in cycle 6; ack in cycle 7; total latency 7.
- Starvation: STARVE_LIMIT=3, PPU requests continuously → dbg_starve_out rises after 3 blocked cycles, stays high, and clears the cycle after the debug grant.
- Debug write/read: debug write $3C to $7FF → ack 2 cycles after request. Debug read of $7FF → dbg_d_out=$3C, held through 10 idle cycles and through intervening PPU reads.
- Reset: rst_in asserted during the cycle after a PPU read grant → no ppu_rd_valid_out. All outputs at reset values and FSM in IDLE the cycle after reset.
